rom_streamer: RTL and testbench

Read sequencer sitting directly upstream of the synchronous ROM. On a start command it walks a contiguous address range, drives the ROM's enable/address, captures the one-cycle-latency read data, and presents it downstream as a valid/ready stream with a last flag. Full throughput (one word per cycle) under continuous ready; lossless under arbitrary backpressure.

---
 rtl/rom_streamer_if.sv | 31 +++
 rtl/rom_streamer.sv | 128 ++++++++++++
 tb/tb_rom_streamer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rom_streamer_if.sv
// Command, ROM-port and output-stream signals of rom_streamer.
// Signal prefixes are from the streamer's side: master = streamer, slave = its environment.
interface rom_streamer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4096
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             i_start;
  logic [AW-1:0]    i_base;
  logic [AW:0]      i_count;
  logic             o_busy;
  logic             o_done;
  logic             o_rom_en;
  logic [AW-1:0]    o_rom_addr;
  logic [WIDTH-1:0] i_rom_data;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [WIDTH-1:0] o_out_data;
  logic             o_out_last;

  modport master (
    input  i_start, i_base, i_count, i_rom_data, i_out_ready,
    output o_busy, o_done, o_rom_en, o_rom_addr, o_out_valid, o_out_data, o_out_last
  );

  modport slave (
    output i_start, i_base, i_count, i_rom_data, i_out_ready,
    input  o_busy, o_done, o_rom_en, o_rom_addr, o_out_valid, o_out_data, o_out_last
  );
endinterface

// File: rtl/rom_streamer.sv
// Walks a contiguous ROM address range on command and streams the read data out
// through a 4-entry skid FIFO with valid/ready and a last flag.
module rom_streamer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4096
) (
  input logic            clk,
  input logic            rst,
  rom_streamer_if.master bus
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned FD   = 4;
  localparam int unsigned PW   = 2;
  localparam int unsigned CW   = 3;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [CNTW-1:0]  r_remain;
  logic             r_rom_en;
  logic             r_rom_last;
  logic [AW-1:0]    r_rom_addr;
  logic             r_cap;
  logic             r_cap_last;
  logic             r_zero_done;
  logic [WIDTH-1:0] r_fifo_data [FD];
  logic [FD-1:0]    r_fifo_last;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_fifo_cnt;

  logic             w_valid;
  logic             w_pop;
  logic             w_last_pop;
  logic             w_issue;
  logic [CW-1:0]    w_pending;
  logic [CW-1:0]    w_outstanding;

  // Pending counts the read on the ROM port plus the word about to be captured, so
  // fifo + pending can never exceed the FIFO depth.
  assign w_valid       = (r_fifo_cnt != '0);
  assign w_pop         = w_valid && bus.i_out_ready;
  assign w_last_pop    = w_pop && r_fifo_last[r_rd_ptr];
  assign w_pending     = CW'(r_rom_en) + CW'(r_cap);
  assign w_outstanding = r_fifo_cnt + w_pending;
  assign w_issue       = (r_state == S_RUN) && (r_remain != '0) && (w_outstanding < CW'(FD));

  assign bus.o_busy      = (r_state == S_RUN);
  assign bus.o_done      = r_zero_done || w_last_pop;
  assign bus.o_rom_en    = r_rom_en;
  assign bus.o_rom_addr  = r_rom_addr;
  assign bus.o_out_valid = w_valid;
  assign bus.o_out_data  = w_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign bus.o_out_last  = w_valid && r_fifo_last[r_rd_ptr];

  // Command FSM, read issue and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remain    <= '0;
      r_rom_en    <= 1'b0;
      r_rom_last  <= 1'b0;
      r_rom_addr  <= '0;
      r_cap       <= 1'b0;
      r_cap_last  <= 1'b0;
      r_zero_done <= 1'b0;
      r_fifo_last <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_cnt  <= '0;
    end else begin
      r_zero_done <= 1'b0;
      r_rom_en    <= 1'b0;
      r_rom_last  <= 1'b0;
      r_cap       <= r_rom_en;
      r_cap_last  <= r_rom_last;

      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            if (bus.i_count == '0) begin
              r_zero_done <= 1'b1;
            end else begin
              r_state    <= S_RUN;
              r_rom_en   <= 1'b1;
              r_rom_addr <= bus.i_base;
              r_rom_last <= (bus.i_count == CNTW'(1));
              r_remain   <= bus.i_count - CNTW'(1);
            end
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_rom_en   <= 1'b1;
            r_rom_addr <= r_rom_addr + AW'(1);
            r_rom_last <= (r_remain == CNTW'(1));
            r_remain   <= r_remain - CNTW'(1);
          end
          if (w_last_pop) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (r_cap) begin
        r_fifo_last[r_wr_ptr] <= r_cap_last;
        r_wr_ptr              <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({r_cap, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Data storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (r_cap) begin
      r_fifo_data[r_wr_ptr] <= bus.i_rom_data;
    end
  end
endmodule

// File: tb/tb_rom_streamer.sv
// Directed bench for rom_streamer with a behavioural ROM holding mem[i] = i & 0xFF.
module tb_rom_streamer;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4096;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;

  rom_streamer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  rom_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One-cycle-latency synchronous ROM.
  always @(posedge clk) begin
    if (bus.o_rom_en) bus.i_rom_data <= bus.o_rom_addr[7:0];
  end

  int n_assert = 0;
  int n_fail   = 0;

  logic [AW-1:0] q_addr [$];
  logic [7:0]    q_data [$];
  logic          q_last [$];
  int            done_cnt;
  int            done_cyc;
  int            max_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.o_busy), 0);
    check({tag, "_done"},  32'(bus.o_done), 0);
    check({tag, "_rom_en"}, 32'(bus.o_rom_en), 0);
    check({tag, "_rom_addr"}, 32'(bus.o_rom_addr), 0);
    check({tag, "_valid"}, 32'(bus.o_out_valid), 0);
    check({tag, "_data"},  32'(bus.o_out_data), 0);
    check({tag, "_last"},  32'(bus.o_out_last), 0);
  endtask

  // Issues one command from a negedge and records issued addresses and transferred words
  // until done is seen (or the budget runs out); returns at the negedge after done.
  task automatic run_cmd(input logic [AW-1:0] b, input logic [AW:0] n, input bit rnd, input int budget);
    int         cyc;
    int         issued;
    int         popped;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    q_addr.delete(); q_data.delete(); q_last.delete();
    done_cnt = 0; done_cyc = -1; max_out = 0;
    issued = 0; popped = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    bus.i_start = 1'b1; bus.i_base = b; bus.i_count = n; bus.i_out_ready = 1'b1;
    tick();
    bus.i_start = 1'b0;
    cyc = 1;
    while (cyc < budget) begin
      bus.i_out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      #1;
      if (bus.o_rom_en) begin
        q_addr.push_back(bus.o_rom_addr);
        issued++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (prev_stall) begin
        check("stall_valid_hold", 32'(bus.o_out_valid), 1);
        check("stall_data_hold", 32'(bus.o_out_data), 32'(prev_data));
        check("stall_last_hold", 32'(bus.o_out_last), 32'(prev_last));
      end
      if (bus.o_out_valid && bus.i_out_ready) begin
        q_data.push_back(bus.o_out_data);
        q_last.push_back(bus.o_out_last);
        popped++;
      end
      prev_stall = bus.o_out_valid && !bus.i_out_ready;
      prev_data  = bus.o_out_data;
      prev_last  = bus.o_out_last;
      if (bus.o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      tick();
      cyc++;
      if (done_cyc >= 0) break;
    end
    bus.i_out_ready = 1'b1;
  endtask

  // A few quiet cycles after a command: nothing may move.
  task automatic check_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"},  32'(bus.o_busy), 0);
      check({tag, "_done"},  32'(bus.o_done), 0);
      check({tag, "_rom_en"}, 32'(bus.o_rom_en), 0);
      check({tag, "_valid"}, 32'(bus.o_out_valid), 0);
      tick();
    end
  endtask

  initial begin
    logic [AW-1:0] exp_addr [4];

    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_base = '0; bus.i_count = '0; bus.i_out_ready = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic command base=0x010 count=4, with a start attempt while busy.
    bus.i_start = 1'b1; bus.i_base = 12'h010; bus.i_count = 13'd4;
    tick();                                            // cycle 1
    bus.i_start = 1'b0;
    check("c1_busy", 32'(bus.o_busy), 1);
    check("c1_rom_en", 32'(bus.o_rom_en), 1);
    check("c1_rom_addr", 32'(bus.o_rom_addr), 32'h010);
    check("c1_valid", 32'(bus.o_out_valid), 0);
    tick();                                            // cycle 2
    check("c2_rom_addr", 32'(bus.o_rom_addr), 32'h011);
    check("c2_valid", 32'(bus.o_out_valid), 0);
    bus.i_start = 1'b1; bus.i_base = 12'h100; bus.i_count = 13'd5;
    tick();                                            // cycle 3
    bus.i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin                  // cycles 3..6
      check("basic_valid", 32'(bus.o_out_valid), 1);
      check("basic_data", 32'(bus.o_out_data), 32'h10 + 32'(k));
      check("basic_last", 32'(bus.o_out_last), (k == 3) ? 1 : 0);
      check("basic_done", 32'(bus.o_done), (k == 3) ? 1 : 0);
      check("basic_busy", 32'(bus.o_busy), 1);
      if (k == 2) begin
        check("c5_rom_en", 32'(bus.o_rom_en), 0);
        check("c5_rom_addr_hold", 32'(bus.o_rom_addr), 32'h013);
      end
      if (k == 3) begin
        bus.i_start = 1'b1; bus.i_base = 12'h200; bus.i_count = 13'd0;
      end
      tick();
    end
    bus.i_start = 1'b0;                                // cycle 7
    check("c7_busy", 32'(bus.o_busy), 0);
    check("c7_done_ignored_start", 32'(bus.o_done), 0);
    check("c7_valid", 32'(bus.o_out_valid), 0);
    check_quiet("after_basic", 3);

    // Address wrap at the top of the ROM.
    run_cmd(12'(DEPTH - 2), 13'd4, 1'b0, 50);
    exp_addr[0] = 12'(DEPTH - 2); exp_addr[1] = 12'(DEPTH - 1); exp_addr[2] = '0; exp_addr[3] = 12'd1;
    check("wrap_n_issue", 32'(q_addr.size()), 4);
    check("wrap_n_words", 32'(q_data.size()), 4);
    if (q_addr.size() == 4 && q_data.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("wrap_addr", 32'(q_addr[k]), 32'(exp_addr[k]));
        check("wrap_data", 32'(q_data[k]), 32'(exp_addr[k][7:0]));
        check("wrap_last", 32'(q_last[k]), (k == 3) ? 1 : 0);
      end
    end
    check("wrap_done_cnt", 32'(done_cnt), 1);
    check("wrap_done_cycle", 32'(done_cyc), 6);
    check("wrap_busy_after", 32'(bus.o_busy), 0);
    check_quiet("after_wrap", 2);

    // Backpressure with roughly 30% ready duty.
    run_cmd(12'h0F8, 13'd16, 1'b1, 600);
    check("bp_n_issue", 32'(q_addr.size()), 16);
    check("bp_n_words", 32'(q_data.size()), 16);
    if (q_data.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        check("bp_data", 32'(q_data[k]), 32'(8'(8'hF8 + k)));
        check("bp_last", 32'(q_last[k]), (k == 15) ? 1 : 0);
      end
    end
    check("bp_outstanding_le4", 32'(max_out <= 4), 1);
    check("bp_done_cnt", 32'(done_cnt), 1);
    check("bp_busy_after", 32'(bus.o_busy), 0);
    check_quiet("after_bp", 3);

    // Zero-length command.
    bus.i_start = 1'b1; bus.i_base = 12'h055; bus.i_count = 13'd0;
    tick();
    bus.i_start = 1'b0;
    check("zero_done_c1", 32'(bus.o_done), 1);
    check("zero_busy_c1", 32'(bus.o_busy), 0);
    check("zero_rom_en_c1", 32'(bus.o_rom_en), 0);
    check("zero_valid_c1", 32'(bus.o_out_valid), 0);
    tick();
    check_quiet("after_zero", 3);

    // Reset in cycle 5 of a stalled 16-word command.
    bus.i_out_ready = 1'b0;
    bus.i_start = 1'b1; bus.i_base = 12'h020; bus.i_count = 13'd16;
    tick();                                            // cycle 1
    bus.i_start = 1'b0;
    tick(); tick(); tick(); tick();                    // cycle 5
    check("rst_pre_valid", 32'(bus.o_out_valid), 1);
    check("rst_pre_busy", 32'(bus.o_busy), 1);
    check("rst_pre_data", 32'(bus.o_out_data), 32'h20);
    rst = 1'b1;
    tick();                                            // cycle 6
    check_reset_outputs("midrst");
    rst = 1'b0;
    bus.i_out_ready = 1'b1;
    tick();
    check_reset_outputs("midrst_after");

    run_cmd(12'h000, 13'd2, 1'b0, 50);
    check("post_rst_n_words", 32'(q_data.size()), 2);
    if (q_data.size() == 2) begin
      check("post_rst_data0", 32'(q_data[0]), 32'h00);
      check("post_rst_data1", 32'(q_data[1]), 32'h01);
      check("post_rst_last1", 32'(q_last[1]), 1);
    end
    check("post_rst_done_cnt", 32'(done_cnt), 1);
    check("post_rst_done_cycle", 32'(done_cyc), 4);
    check_quiet("end", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
